// File: rtl/loa_adder_pkg.sv
// Shared definitions for the pipelined lower-part-OR adder: defaults,
// segment geometry helpers and the default-width stage payload.
package loa_adder_pkg;

    localparam int DEF_WIDTH       = 32;
    localparam int DEF_APPROX_BITS = 8;
    localparam int DEF_STAGES      = 4;

    // Nominal segment width: ceil(exact bits / stages).
    function automatic int seg_width(input int width, input int approx_bits, input int stages);
        return (width - approx_bits + stages - 1) / stages;
    endfunction

    function automatic int seg_lo(input int width, input int approx_bits, input int stages, input int s);
        int exact_bits;
        int lo;
        exact_bits = width - approx_bits;
        lo         = s * seg_width(width, approx_bits, stages);
        return (lo > exact_bits) ? exact_bits : lo;
    endfunction

    // The last segment always ends at the top bit and absorbs the remainder.
    function automatic int seg_hi(input int width, input int approx_bits, input int stages, input int s);
        int exact_bits;
        int hi;
        exact_bits = width - approx_bits;
        hi         = (s + 1) * seg_width(width, approx_bits, stages);
        if (s == stages - 1) return exact_bits;
        return (hi > exact_bits) ? exact_bits : hi;
    endfunction

    typedef struct packed {
        logic                                   valid;
        logic [DEF_WIDTH-1:0]                   sum;
        logic [DEF_WIDTH-DEF_APPROX_BITS-1:0]   opa;
        logic [DEF_WIDTH-DEF_APPROX_BITS-1:0]   opb;
        logic                                   carry;
    } loa_stage_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule

// File: rtl/rca_segment.sv
// Combinational ripple-carry segment of W bits built from full_adder cells.
module rca_segment #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);

    for (genvar i = 0; i < W; i++) begin : g_bit
        logic w_ci;
        logic w_co;
        if (i == 0) begin : g_first
            assign w_ci = i_cin;
        end else begin : g_next
            assign w_ci = g_bit[i-1].w_co;
        end
        full_adder u_fa (
            .i_a (i_a[i]),
            .i_b (i_b[i]),
            .i_c (w_ci),
            .o_s (o_sum[i]),
            .o_c (w_co)
        );
    end

    assign o_cout = g_bit[W-1].w_co;

endmodule

// File: rtl/pipelined_loa_adder.sv
// Pipelined lower-part-OR approximate adder with valid/ready streaming.
// Optional LOA_ERROR_DISTANCE_EN adds err_o = |exact sum - result_o|.
module pipelined_loa_adder
    import loa_adder_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int APPROX_BITS = DEF_APPROX_BITS,
    parameter int STAGES      = DEF_STAGES
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] add1_i,
    input  logic [WIDTH-1:0] add2_i,
    input  logic             carry_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH:0]   result_o,
    output logic             valid_o,
`ifdef LOA_ERROR_DISTANCE_EN
    output logic [WIDTH:0]   err_o,
`endif
    input  logic             ready_i
);

    localparam int K     = APPROX_BITS;
    localparam int EXACT = WIDTH - APPROX_BITS;

    // Handshake: a beat moves on a rising edge when valid and ready are both
    // high; the whole pipe advances together whenever the output slot is empty
    // or being drained, so ready_o never depends on valid_i.
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] sum;
        logic [EXACT-1:0] opa;
        logic [EXACT-1:0] opb;
        logic             carry;
    } stage_t;

    stage_t r_stage [0:STAGES];
    stage_t w_next  [0:STAGES];
    logic   w_en;

    assign w_en     = ~r_stage[STAGES].valid | ready_i;
    assign ready_o  = w_en;
    assign valid_o  = r_stage[STAGES].valid;
    assign result_o = {r_stage[STAGES].carry, r_stage[STAGES].sum};

    logic [WIDTH-1:0] w_sum0;
    logic             w_cin0;

    if (K > 0) begin : g_loa
        logic w_unused_carry;
        assign w_sum0         = {{EXACT{1'b0}}, add1_i[K-1:0] | add2_i[K-1:0]};
        assign w_cin0         = add1_i[K-1] & add2_i[K-1];
        assign w_unused_carry = carry_i;
    end else begin : g_exact
        assign w_sum0 = '0;
        assign w_cin0 = carry_i;
    end

    assign w_next[0] = '{valid: valid_i, sum: w_sum0, opa: add1_i[WIDTH-1:K],
                         opb: add2_i[WIDTH-1:K], carry: w_cin0};

    // Stage g+1 adds exact segment g; operands travel unchanged alongside.
    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        localparam int LO = seg_lo(WIDTH, K, STAGES, g);
        localparam int HI = seg_hi(WIDTH, K, STAGES, g);
        localparam int SW = HI - LO;

        logic [WIDTH-1:0] w_sum;
        logic             w_cout;

        if (SW > 0) begin : g_seg
            logic [SW-1:0] w_seg_sum;
            rca_segment #(.W(SW)) u_seg (
                .i_a    (r_stage[g].opa[HI-1:LO]),
                .i_b    (r_stage[g].opb[HI-1:LO]),
                .i_cin  (r_stage[g].carry),
                .o_sum  (w_seg_sum),
                .o_cout (w_cout)
            );
            always_comb begin
                w_sum              = r_stage[g].sum;
                w_sum[K+HI-1:K+LO] = w_seg_sum;
            end
        end else begin : g_pass
            assign w_sum  = r_stage[g].sum;
            assign w_cout = r_stage[g].carry;
        end

        assign w_next[g+1] = '{valid: r_stage[g].valid, sum: w_sum, opa: r_stage[g].opa,
                               opb: r_stage[g].opb, carry: w_cout};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i <= STAGES; i++) r_stage[i] <= '0;
        end else if (w_en) begin
            for (int i = 0; i <= STAGES; i++) r_stage[i] <= w_next[i];
        end
    end

`ifdef LOA_ERROR_DISTANCE_EN
    logic [WIDTH:0] r_exact [0:STAGES-1];
    logic [WIDTH:0] r_err;
    logic [WIDTH:0] w_exact0;
    logic [WIDTH:0] w_res_last;
    logic [WIDTH:0] w_err_next;
    logic           w_cin_exact;

    assign w_cin_exact = (K == 0) ? carry_i : 1'b0;
    assign w_exact0    = {1'b0, add1_i} + {1'b0, add2_i} + {{WIDTH{1'b0}}, w_cin_exact};
    assign w_res_last  = {w_next[STAGES].carry, w_next[STAGES].sum};
    // The LOA result can land on either side of the exact sum.
    assign w_err_next  = (r_exact[STAGES-1] >= w_res_last) ? r_exact[STAGES-1] - w_res_last
                                                          : w_res_last - r_exact[STAGES-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < STAGES; i++) r_exact[i] <= '0;
            r_err <= '0;
        end else if (w_en) begin
            r_exact[0] <= w_exact0;
            for (int i = 1; i < STAGES; i++) r_exact[i] <= r_exact[i-1];
            r_err <= w_err_next;
        end
    end

    assign err_o = r_err;
`endif

endmodule

// File: tb/tb_pipelined_loa_adder.sv
// Bench for pipelined_loa_adder: vector table, stall stream, random traffic,
// mid-stream reset and an exact (APPROX_BITS=0) instance.
module tb_pipelined_loa_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] add1, add2;
    logic        carry, valid_in, ready_out, valid_out, ready_in;
    logic [32:0] result;
    logic [31:0] x_add1, x_add2;
    logic        x_carry, x_valid_in, x_ready_out, x_valid_out, x_ready_in;
    logic [32:0] x_result;
`ifdef LOA_ERROR_DISTANCE_EN
    logic [32:0] err;
    logic [32:0] x_err;
`endif

    pipelined_loa_adder #(.WIDTH(32), .APPROX_BITS(8), .STAGES(4)) u_dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .add1_i   (add1),
        .add2_i   (add2),
        .carry_i  (carry),
        .valid_i  (valid_in),
        .ready_o  (ready_out),
        .result_o (result),
        .valid_o  (valid_out),
`ifdef LOA_ERROR_DISTANCE_EN
        .err_o    (err),
`endif
        .ready_i  (ready_in)
    );

    pipelined_loa_adder #(.WIDTH(32), .APPROX_BITS(0), .STAGES(4)) u_dut_exact (
        .clk_i    (clk),
        .rst_i    (rst),
        .add1_i   (x_add1),
        .add2_i   (x_add2),
        .carry_i  (x_carry),
        .valid_i  (x_valid_in),
        .ready_o  (x_ready_out),
        .result_o (x_result),
        .valid_o  (x_valid_out),
`ifdef LOA_ERROR_DISTANCE_EN
        .err_o    (x_err),
`endif
        .ready_i  (x_ready_in)
    );

    int checks = 0;
    int errors = 0;
    int rx_count = 0;
    int stall_cnt = 0;
    logic [32:0] exp_q[$];
    logic [32:0] exp_err_q[$];
    logic        prev_stall = 1'b0;
    logic [32:0] prev_result = '0;
    logic        rnd_done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: OR the low k bits, add the upper bits as plain integers.
    function automatic logic [32:0] model_loa(input logic [31:0] a, input logic [31:0] b,
                                              input logic cin, input int k);
        longint unsigned ua, ub, mask, low, upper, c;
        ua    = a;
        ub    = b;
        mask  = (64'd1 << k) - 1;
        low   = (ua | ub) & mask;
        c     = (k > 0) ? (((ua >> (k - 1)) & (ub >> (k - 1))) & 1) : longint'(cin);
        upper = (ua >> k) + (ub >> k) + c;
        return 33'((upper << k) | low);
    endfunction

    function automatic logic [32:0] model_err(input logic [31:0] a, input logic [31:0] b,
                                              input logic cin, input int k);
        longint unsigned exact, approx;
        exact  = longint'(a) + longint'(b) + ((k == 0) ? longint'(cin) : 0);
        approx = model_loa(a, b, cin, k);
        return 33'((exact >= approx) ? exact - approx : approx - exact);
    endfunction

    // Scoreboard and protocol monitor for the approximate instance.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_err_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (valid_in && ready_out) begin
                exp_q.push_back(model_loa(add1, add2, carry, 8));
                exp_err_q.push_back(model_err(add1, add2, carry, 8));
            end
            check("ready_rule", {63'd0, ready_out}, {63'd0, !(valid_out && !ready_in)});
            if (prev_stall) check("stall_hold", {31'd0, result}, {31'd0, prev_result});
            if (valid_out && ready_in) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%0h required=none at %0t", result, $time);
                end else begin
                    check("sb_result", {31'd0, result}, {31'd0, exp_q.pop_front()});
`ifdef LOA_ERROR_DISTANCE_EN
                    check("sb_err", {31'd0, err}, {31'd0, exp_err_q.pop_front()});
`else
                    void'(exp_err_q.pop_front());
`endif
                    rx_count++;
                end
            end
            if (valid_out && !ready_in) stall_cnt++;
            prev_stall  = valid_out && !ready_in;
            prev_result = result;
        end
    end

    // Presents one beat and holds it until taken; returns 1 time unit after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic c);
        int n;
        n        = 0;
        add1     = a;
        add2     = b;
        carry    = c;
        valid_in = 1'b1;
        @(negedge clk);
        while (!ready_out && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("send_timeout", 64'(n), 64'd0);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [32:0] res;
        logic [32:0] err;
        string       name;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int n;
        send(v.a, v.b, 1'b0);
        n = 1;
        while (!valid_out && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({"lat_", v.name}, 64'(n), 64'd5);
        check({"res_", v.name}, {31'd0, result}, {31'd0, v.res});
`ifdef LOA_ERROR_DISTANCE_EN
        check({"err_", v.name}, {31'd0, err}, {31'd0, v.err});
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic run_exact(input logic [31:0] a, input logic [31:0] b, input logic c,
                             input logic [32:0] expected, input string name);
        int n;
        x_add1     = a;
        x_add2     = b;
        x_carry    = c;
        x_valid_in = 1'b1;
        @(negedge clk);
        check({"xready_", name}, {63'd0, x_ready_out}, 64'd1);
        @(posedge clk);
        #1;
        x_valid_in = 1'b0;
        n = 1;
        while (!x_valid_out && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({"xlat_", name}, 64'(n), 64'd5);
        check({"xres_", name}, {31'd0, x_result}, {31'd0, expected});
`ifdef LOA_ERROR_DISTANCE_EN
        check({"xerr_", name}, {31'd0, x_err}, 64'd0);
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[6];
        int   rx0, n, stale;
        logic [31:0] ra, rb;

        vecs[0] = '{32'h000000F0, 32'h0000000F, 33'h0_000000FF, 33'h0,   "f0_0f"};
        vecs[1] = '{32'h00000003, 32'h00000001, 33'h0_00000003, 33'h1,   "3_1"};
        vecs[2] = '{32'hFFFFFFFF, 32'h00000001, 33'h0_FFFFFFFF, 33'h1,   "ones_1"};
        vecs[3] = '{32'h80000080, 32'h80000080, 33'h1_00000180, 33'h80,  "msb_b7"};
        vecs[4] = '{32'h00000080, 32'h00000080, 33'h0_00000180, 33'h80,  "b7_only"};
        vecs[5] = '{32'hFFFFFF00, 32'h00000100, 33'h1_00000000, 33'h0,   "upper_wrap"};

        rst = 1'b1;
        add1 = '0; add2 = '0; carry = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
        x_add1 = '0; x_add2 = '0; x_carry = 1'b0; x_valid_in = 1'b0; x_ready_in = 1'b1;
        rnd_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {63'd0, valid_out}, 64'd0);
        check("rst_result", {31'd0, result}, 64'd0);
        check("rst_ready", {63'd0, ready_out}, 64'd1);
        check("rst_x_valid", {63'd0, x_valid_out}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Back-to-back stream with a three-cycle downstream stall.
        rx0 = rx_count;
        stall_cnt = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)));
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                ready_in = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                ready_in = 1'b1;
            end
        join
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("stream_drain", 64'(exp_q.size()), 64'd0);
        check("stream_count", 64'(rx_count - rx0), 64'd8);
        check("stall_seen", {63'd0, stall_cnt > 0}, 64'd1);
        #1;

        // Random operands, random gaps, random backpressure.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    int gap;
                    gap = $urandom_range(0, 2);
                    repeat (gap) begin
                        @(posedge clk);
                        #1;
                    end
                    ra = $urandom;
                    rb = $urandom;
                    if ($urandom_range(0, 1) == 1) begin
                        ra = ra | 32'h80;
                        rb = rb | 32'h80;
                    end
                    send(ra, rb, 1'($urandom_range(0, 1)));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    ready_in = ($urandom_range(0, 3) != 0);
                end
            end
        join
        ready_in = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("random_drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;

        // Asynchronous reset with several beats in flight.
        for (int i = 0; i < 6; i++) send($urandom, $urandom, 1'b0);
        check("pre_rst_valid", {63'd0, valid_out}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", {63'd0, valid_out}, 64'd0);
        check("async_rst_result", {31'd0, result}, 64'd0);
        check("async_rst_ready", {63'd0, ready_out}, 64'd1);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        stale = 0;
        repeat (12) begin
            @(negedge clk);
            if (valid_out) stale++;
        end
        check("no_stale_beat", 64'(stale), 64'd0);
        @(posedge clk);
        #1;
        run_vec(vecs[3]);

        // Exact instance: carry_i is honoured when no bits are approximated.
        run_exact(32'hFFFFFFFF, 32'h00000000, 1'b1, 33'h1_00000000, "cin_wrap");
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            run_exact(ra, rb, 1'(i & 1), model_loa(ra, rb, 1'(i & 1), 0), "rand");
        end

        check("final_queue", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
